mem_stage: RTL
==============

# mem_stage

Memory stage of the MIPS pipeline: it consumes the EXE stage's registered outputs (ALU result, store data, MemRead/MemWrite, ALU_Control, destination register) and performs the load/store against the data-memory port with a request/acknowledge handshake. Results and the write-back controls are registered toward WB, and the memory-stage result is driven back to EXE as `Mem_result_forward`. While a memory access is outstanding, the stage asserts a stall to freeze the upstream stages.

## Interface
- `TIMEOUT_CYCLES`, 16: maximum wait cycles for `MemAck_fDM` before the access is aborted.
- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-low.
- `Instr1_IN`, `Instr1_PC_IN` in 32 each: instruction and PC [debug], from EXE.
- `ALU_result1_IN` in 32: ALU result; the effective address for memory ops.
- `MemWriteData1_IN` in 32: store data.
- `WriteRegister1_IN` in 5, `RegWrite1_IN` in 1: destination register and write enable.
- `ALU_Control1_IN` in 6: selects the memory sub-op.
- `MemRead1_IN`, `MemWrite1_IN` in 1 each: access type.
- `data_address_2DM` out 32: word address, with bits [1:0]=0.
- `data_write_2DM` out 32: lane-replicated store data.
- `data_be_2DM` out 4: byte enables; bit 3 is bits [31:24].
- `MemRead_2DM`, `MemWrite_2DM` out 1 each: request strobes, held until ack.
- `data_read_fDM` in 32: read data, valid with ack.
- `MemAck_fDM` in 1: access complete.
- `Instr1_OUT`, `Instr1_PC_OUT` out 32 each: to WB.
- `WriteData1_OUT` out 32: loaded value or passed-through ALU result.
- `WriteRegister1_OUT` out 5, `RegWrite1_OUT` out 1: to WB.
- `Mem_result_forward` out 32: equal to `WriteData1_OUT`; drives the EXE forwarding mux select value 2.
- `STALL_OUT` out 1: freeze PC/IF/ID/EXE registers.
- `MemTimeout_OUT` out 1: sticky timeout error.
- `AddrErr_OUT` out 1: misaligned-access pulse; present only with `MEM_ALIGN_CHECK_EN`.

## Operation
- FSM states are IDLE and WAIT.
- **IDLE, no memory op:** on the clock edge, register the inputs into the outputs; `WriteData1_OUT` takes `ALU_result1_IN`.
- **IDLE, `MemRead1_IN` or `MemWrite1_IN` set:** latch the op, address, data and destination; go to WAIT. `STALL_OUT` is 1 combinationally in this same cycle.
- **WAIT:** drive the request from the latched op. On `MemAck_fDM`=1:
  - a load writes the extracted value to `WriteData1_OUT` with `RegWrite1_OUT` as latched;
  - a store writes with `RegWrite1_OUT`=0;
  - the FSM returns to IDLE.
- `STALL_OUT` = (IDLE & memory op in) | (WAIT & !`MemAck_fDM`).
- While stalled, WB outputs carry a bubble: `RegWrite1_OUT`=0, `Instr1_OUT`=0.
- Upstream holds the EXE inputs stable while `STALL_OUT`=1.
- The wait counter increments each WAIT cycle without ack. When it reaches `TIMEOUT_CYCLES`:
  - drop the request, write a bubble and return to IDLE;
  - set `MemTimeout_OUT`, which stays 1 until reset;
  - the stall is released in that cycle.
- Byte order is big-endian; `off` = address[1:0].
- **Loads:**
  - lb/lbu select byte lane (3−off).
  - lh/lhu select the half at bits [31:16] when off[1]=0, else bits [15:0].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw takes the full word.
- **Stores:**
  - sb replicates the byte ×4 with `data_be_2DM` = 4'b1000>>off.
  - sh replicates the half ×2 with enables 1100 or 0011.
  - sw uses enables 1111.
- Read requests drive `data_be_2DM`=1111.
- An ack arriving in IDLE is ignored.
- `MemRead1_IN` and `MemWrite1_IN` both set is treated as a store.

## Timing
- Non-memory op: 1-cycle latency.
- Memory op: 1 + N cycles, where N is the number of cycles until ack (N ≥ 1).
- Request strobes are registered and rise in the first WAIT cycle. Ack may arrive in that same cycle.
- Reset (asynchronous, any state, including mid-access):
  - all outputs go to 0 and the FSM goes to IDLE;
  - the counter, latches and `MemTimeout_OUT` clear;
  - request strobes deassert immediately.
- The `Mem_result_forward` update and the stall release happen on the same edge.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A misaligned access raises `AddrErr_OUT` for 1 cycle. Misaligned means lh/lhu/sh with address[0]=1, or lw/sw with address[1:0]≠0.
  - No request is issued, the stage does not stall, and a bubble goes to WB.
- Undefined:
  - The offending low bits are forced to 0 and the access proceeds.
  - The `AddrErr_OUT` port does not exist.

## Structure
- The shared package `mips_pkg` holds:
  - the ALU_Control memory sub-op constants ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_SB, ALU_SH, ALU_SW, with the decoder's existing values;
  - the FSM state encoding.
- One sub-module, `mem_align`: combinational load extraction/extension and store lane/byte-enable generation.

## Test plan
- **Add pass-through:** add with result 0x0000_1234 and RegWrite=1 → next cycle `WriteData1_OUT`=0x1234 and `RegWrite1_OUT`=1, with no stall.
- **lb with sign extension:** lb at address 0x103, memory word 0x1122_33F0, ack after 3 cycles.
  - `STALL_OUT`=1 for 3 cycles;
  - then `WriteData1_OUT`=0xFFFF_FFF0;
  - lbu at the same address → 0x0000_00F0.
- **sh lane replication:** sh at address 0x102 with data 0xAAAA_BEEF → `data_write_2DM`=0xBEEF_BEEF, `data_be_2DM`=0011, `RegWrite1_OUT`=0.
- **Timeout:** lw with no ack, `TIMEOUT_CYCLES`=16 → after 16 WAIT cycles the request drops, `MemTimeout_OUT`=1 stays set, and the stall clears.
- **Reset mid-access:** assert `RESET`=0 during WAIT → the strobes and all outputs are 0 immediately and the FSM is in IDLE after release.
- **Misaligned word access:** lw at address 0x102.
  - With `MEM_ALIGN_CHECK_EN`: 1-cycle `AddrErr_OUT` pulse, no request, bubble to WB.
  - Without it: `data_address_2DM`=0x100.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants: ALU_Control memory sub-op codes and memory stage FSM states
package mips_pkg;

  localparam logic [5:0] ALU_LB  = 6'h20;
  localparam logic [5:0] ALU_LH  = 6'h21;
  localparam logic [5:0] ALU_LW  = 6'h23;
  localparam logic [5:0] ALU_LBU = 6'h24;
  localparam logic [5:0] ALU_LHU = 6'h25;
  localparam logic [5:0] ALU_SB  = 6'h28;
  localparam logic [5:0] ALU_SH  = 6'h29;
  localparam logic [5:0] ALU_SW  = 6'h2B;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - big-endian load extraction/extension and store lane replication/byte enables
// Optional misalignment flag output only with MEM_ALIGN_CHECK_EN.
module mem_align
  import mips_pkg::*;
(
  input  logic [5:0]  i_ctrl,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        o_misaligned,
`endif
  output logic [31:0] o_load,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // offset 0 addresses the most significant byte
  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];

  always_comb begin
    o_load  = i_rdata;
    o_wdata = i_wdata;
    o_be    = 4'b1111;
    case (i_ctrl)
      ALU_LB:  o_load = {{24{w_byte[7]}}, w_byte};
      ALU_LBU: o_load = {24'h0, w_byte};
      ALU_LH:  o_load = {{16{w_half[15]}}, w_half};
      ALU_LHU: o_load = {16'h0, w_half};
      ALU_SB: begin
        o_wdata = {4{i_wdata[7:0]}};
        o_be    = 4'b1000 >> i_off;
      end
      ALU_SH: begin
        o_wdata = {2{i_wdata[15:0]}};
        o_be    = i_off[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign o_misaligned = (((i_ctrl == ALU_LH) || (i_ctrl == ALU_LHU) || (i_ctrl == ALU_SH)) && i_off[0])
                     || (((i_ctrl == ALU_LW) || (i_ctrl == ALU_SW)) && (i_off != 2'b00));
`endif

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: data-memory request/ack handshake, stall, timeout, WB registers
// MEM_ALIGN_CHECK_EN rejects misaligned accesses and adds AddrErr_OUT.
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr1_IN,
  input  logic [31:0] Instr1_PC_IN,
  input  logic [31:0] ALU_result1_IN,
  input  logic [31:0] MemWriteData1_IN,
  input  logic [4:0]  WriteRegister1_IN,
  input  logic        RegWrite1_IN,
  input  logic [5:0]  ALU_Control1_IN,
  input  logic        MemRead1_IN,
  input  logic        MemWrite1_IN,
  output logic [31:0] data_address_2DM,
  output logic [31:0] data_write_2DM,
  output logic [3:0]  data_be_2DM,
  output logic        MemRead_2DM,
  output logic        MemWrite_2DM,
  input  logic [31:0] data_read_fDM,
  input  logic        MemAck_fDM,
  output logic [31:0] Instr1_OUT,
  output logic [31:0] Instr1_PC_OUT,
  output logic [31:0] WriteData1_OUT,
  output logic [4:0]  WriteRegister1_OUT,
  output logic        RegWrite1_OUT,
  output logic [31:0] Mem_result_forward,
  output logic        STALL_OUT,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        AddrErr_OUT,
`endif
  output logic        MemTimeout_OUT
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_ctrl;
  logic [31:0]   r_addr, r_wdata, r_instr, r_pc;
  logic [4:0]    r_wreg;
  logic          r_regwrite, r_mem_read, r_mem_write;

  logic        w_wait, w_mem_op_in, w_bad, w_start, w_timeout, w_req;
  logic [5:0]  w_ctrl;
  logic [1:0]  w_off;
  logic [31:0] w_load, w_st_data;
  logic [3:0]  w_st_be;
`ifdef MEM_ALIGN_CHECK_EN
  logic        w_misaligned;
`endif

  assign w_wait      = (r_state == ST_WAIT);
  assign w_mem_op_in = MemRead1_IN | MemWrite1_IN;
  // In IDLE the aligner looks at the incoming op for the misalignment check
  assign w_ctrl      = w_wait ? r_ctrl : ALU_Control1_IN;
  assign w_off       = w_wait ? r_addr[1:0] : ALU_result1_IN[1:0];

  mem_align u_align (
    .i_ctrl       (w_ctrl),
    .i_off        (w_off),
    .i_rdata      (data_read_fDM),
    .i_wdata      (r_wdata),
`ifdef MEM_ALIGN_CHECK_EN
    .o_misaligned (w_misaligned),
`endif
    .o_load       (w_load),
    .o_wdata      (w_st_data),
    .o_be         (w_st_be)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign w_bad = w_mem_op_in & w_misaligned & ~w_wait;
`else
  assign w_bad = 1'b0;
`endif

  assign w_start   = ~w_wait & w_mem_op_in & ~w_bad;
  assign w_timeout = w_wait & ~MemAck_fDM & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign STALL_OUT = RESET & (w_start | (w_wait & ~MemAck_fDM & ~w_timeout));

  assign w_req              = r_mem_read | r_mem_write;
  assign MemRead_2DM        = r_mem_read;
  assign MemWrite_2DM       = r_mem_write;
  assign data_address_2DM   = w_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign data_write_2DM     = r_mem_write ? w_st_data : 32'h0;
  assign data_be_2DM        = r_mem_write ? w_st_be : (r_mem_read ? 4'hF : 4'h0);
  assign Mem_result_forward = WriteData1_OUT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;  r_cnt <= '0;     r_ctrl <= '0;
      r_addr <= '0;        r_wdata <= '0;   r_instr <= '0;  r_pc <= '0;
      r_wreg <= '0;        r_regwrite <= 1'b0;
      r_mem_read <= 1'b0;  r_mem_write <= 1'b0;
      Instr1_OUT <= '0;    Instr1_PC_OUT <= '0;  WriteData1_OUT <= '0;
      WriteRegister1_OUT <= '0;  RegWrite1_OUT <= 1'b0;  MemTimeout_OUT <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      AddrErr_OUT <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      AddrErr_OUT <= 1'b0;
`endif
      if (!w_wait) begin
        r_cnt <= '0;
        if (w_start) begin
          r_state     <= ST_WAIT;
          r_ctrl      <= ALU_Control1_IN;
          r_addr      <= ALU_result1_IN;
          r_wdata     <= MemWriteData1_IN;
          r_instr     <= Instr1_IN;
          r_pc        <= Instr1_PC_IN;
          r_wreg      <= WriteRegister1_IN;
          r_regwrite  <= RegWrite1_IN;
          r_mem_read  <= ~MemWrite1_IN;
          r_mem_write <= MemWrite1_IN;
          Instr1_OUT    <= '0;
          RegWrite1_OUT <= 1'b0;
        end else if (w_mem_op_in) begin
          Instr1_OUT    <= '0;
          RegWrite1_OUT <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          AddrErr_OUT   <= 1'b1;
`endif
        end else begin
          Instr1_OUT         <= Instr1_IN;
          Instr1_PC_OUT      <= Instr1_PC_IN;
          WriteData1_OUT     <= ALU_result1_IN;
          WriteRegister1_OUT <= WriteRegister1_IN;
          RegWrite1_OUT      <= RegWrite1_IN;
        end
      end else if (MemAck_fDM) begin
        r_state            <= ST_IDLE;
        r_mem_read         <= 1'b0;
        r_mem_write        <= 1'b0;
        Instr1_OUT         <= r_instr;
        Instr1_PC_OUT      <= r_pc;
        WriteRegister1_OUT <= r_wreg;
        WriteData1_OUT     <= r_mem_write ? r_addr : w_load;
        RegWrite1_OUT      <= r_mem_write ? 1'b0 : r_regwrite;
      end else if (w_timeout) begin
        r_state        <= ST_IDLE;
        r_mem_read     <= 1'b0;
        r_mem_write    <= 1'b0;
        MemTimeout_OUT <= 1'b1;
        Instr1_OUT     <= '0;
        RegWrite1_OUT  <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
